nibble_frame_executor: RTL and testbench

- Consumes assembled program frames (addr/cmd/wdata, valid/ready) from the serial nibble deframer and executes them against the nibbleCPU program memory and run control.
- Every frame gets a response on a nibble-wide return channel, so the host can check each command result and read memory back.
- Sits between the deframer and the program RAM / CPU core.

---
 rtl/nibble_frame_executor.sv | 189 ++++++++++++++++++
 tb/tb_nibble_frame_executor.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_frame_executor.sv
`default_nettype none
// ============================================================================
// Module      : nibble_frame_executor
// Description : Executes assembled program frames (WRITE / READ / RUN / HALT)
//               against the nibbleCPU program RAM and run control, and answers
//               every frame on a nibble-wide valid/ready return channel.
//               Non-read commands answer with one nibble (ACK or ERR); READ
//               answers with the 32-bit word as 8 nibbles, LSB nibble first.
// Optional    : NIBBLE_EXEC_WPROT_EN - when defined, a WRITE accepted while
//               cpu_run=1 is rejected with ERR and does not touch the RAM.
// Ports       : clk, rst_n (sync, active low)
//               frame_addr/cmd/wdata/valid -> frame_ready   (frame input)
//               mem_addr/wdata/we/re, mem_rdata             (program RAM)
//               cpu_run                                     (CPU run level)
//               resp_nibble/resp_valid <- resp_ready        (response out)
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_frame_executor #(
  parameter int         ADDR_W     = 10,
  parameter logic [3:0] ACK_NIBBLE = 4'hA,
  parameter logic [3:0] ERR_NIBBLE = 4'hE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [11:0]       frame_addr,
  input  logic [7:0]        frame_cmd,
  input  logic [31:0]       frame_wdata,
  input  logic              frame_valid,
  output logic              frame_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [31:0]       mem_rdata,
  output logic              cpu_run,
  output logic [3:0]        resp_nibble,
  output logic              resp_valid,
  input  logic              resp_ready
);

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;
  localparam logic [7:0] CMD_RUN   = 8'h03;
  localparam logic [7:0] CMD_HALT  = 8'h04;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WRITE   = 3'd1,
    S_RD_REQ  = 3'd2,
    S_RD_WAIT = 3'd3,
    S_RESP    = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       resp_data_q;   // response word; single-nibble replies live in [3:0]
  logic [2:0]        idx_q;         // nibble currently offered
  logic [2:0]        last_q;        // index of the final nibble (0 or 7)
  logic              cpu_run_q;

  logic              accept;
  logic              addr_ok;
  logic              wprot_block;
  state_e            dec_state;
  logic [3:0]        dec_code;
  logic              dec_run_set;
  logic              dec_run_clr;

  // Shifting out the in-range bits leaves only the bits that must be zero;
  // this also degenerates cleanly to "always OK" when ADDR_W is 12.
  assign addr_ok = ((frame_addr >> ADDR_W) == 12'd0);

`ifdef NIBBLE_EXEC_WPROT_EN
  assign wprot_block = cpu_run_q;
`else
  assign wprot_block = 1'b0;
`endif

  assign accept = (state_q == S_IDLE) && frame_valid;

  // Command decode: where the frame goes after acceptance and what it answers.
  always_comb begin
    dec_state   = S_RESP;
    dec_code    = ERR_NIBBLE;
    dec_run_set = 1'b0;
    dec_run_clr = 1'b0;
    case (frame_cmd)
      CMD_WRITE: begin
        if (addr_ok && !wprot_block) begin
          dec_state = S_WRITE;
          dec_code  = ACK_NIBBLE;
        end
      end
      CMD_READ: begin
        if (addr_ok) begin
          dec_state = S_RD_REQ;
          dec_code  = ACK_NIBBLE;
        end
      end
      CMD_RUN: begin
        dec_code    = ACK_NIBBLE;
        dec_run_set = 1'b1;
      end
      CMD_HALT: begin
        dec_code    = ACK_NIBBLE;
        dec_run_clr = 1'b1;
      end
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and control strobes.
  always_comb begin
    state_d     = state_q;
    frame_ready = 1'b0;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    resp_valid  = 1'b0;
    case (state_q)
      S_IDLE: begin
        frame_ready = 1'b1;
        if (frame_valid) state_d = dec_state;
      end
      S_WRITE: begin
        mem_we  = 1'b1;
        state_d = S_RESP;
      end
      S_RD_REQ: begin
        mem_re  = 1'b1;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready && (idx_q == last_q)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Frame capture, response buffer and run control.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      resp_data_q <= '0;
      idx_q       <= '0;
      last_q      <= '0;
      cpu_run_q   <= 1'b0;
    end else begin
      if (accept) begin
        addr_q      <= frame_addr[ADDR_W-1:0];
        wdata_q     <= frame_wdata;
        resp_data_q <= {28'd0, dec_code};
        idx_q       <= 3'd0;
        last_q      <= 3'd0;
        if (dec_run_set) cpu_run_q <= 1'b1;
        if (dec_run_clr) cpu_run_q <= 1'b0;
      end
      // RAM data arrives the cycle after the read strobe.
      if (state_q == S_RD_WAIT) begin
        resp_data_q <= mem_rdata;
        last_q      <= 3'd7;
      end
      if ((state_q == S_RESP) && resp_ready) begin
        idx_q <= idx_q + 3'd1;
      end
    end
  end

  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign cpu_run     = cpu_run_q;
  assign resp_nibble = resp_valid ? resp_data_q[{idx_q, 2'b00} +: 4] : 4'h0;

endmodule
`default_nettype wire

// File: tb/tb_nibble_frame_executor.sv
`default_nettype none
// ============================================================================
// Module      : tb_nibble_frame_executor
// Description : Self-checking bench for nibble_frame_executor. A word-level
//               model (expected RAM contents, run flag, expected nibble list)
//               predicts every response; a behavioural RAM serves the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_frame_executor;

  localparam int AW = 10;
`ifdef NIBBLE_EXEC_WPROT_EN
  localparam bit WPROT = 1'b1;
`else
  localparam bit WPROT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [11:0]   frame_addr;
  logic [7:0]    frame_cmd;
  logic [31:0]   frame_wdata;
  logic          frame_valid;
  logic          frame_ready;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_we;
  logic          mem_re;
  logic [31:0]   mem_rdata;
  logic          cpu_run;
  logic [3:0]    resp_nibble;
  logic          resp_valid;
  logic          resp_ready;

  nibble_frame_executor #(.ADDR_W(AW), .ACK_NIBBLE(4'hA), .ERR_NIBBLE(4'hE)) dut (
    .clk(clk), .rst_n(rst_n),
    .frame_addr(frame_addr), .frame_cmd(frame_cmd), .frame_wdata(frame_wdata),
    .frame_valid(frame_valid), .frame_ready(frame_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .cpu_run(cpu_run),
    .resp_nibble(resp_nibble), .resp_valid(resp_valid), .resp_ready(resp_ready)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Environment RAM (serves the DUT) and the model's view of memory.
  logic [31:0] ram     [1024];
  logic [31:0] ref_mem [1024];
  logic        ref_run;

  int we_cnt = 0, re_cnt = 0, both_cnt = 0;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
    if (rst_n) begin
      if (mem_we) we_cnt <= we_cnt + 1;
      if (mem_re) re_cnt <= re_cnt + 1;
      if (mem_we && mem_re) both_cnt <= both_cnt + 1;
    end
  end

  // Model outputs for the current frame.
  logic [3:0] exp_q[$];
  logic [3:0] got_q[$];
  int exp_we, exp_re, exp_lat;
  int first_lat, busy_ready, stable_err;

  task automatic model(input logic [11:0] a, input logic [7:0] c, input logic [31:0] d);
    logic [31:0] w;
    bit in_range;
    in_range = (int'(a) < (1 << AW));
    exp_q.delete(); exp_we = 0; exp_re = 0; exp_lat = 0;
    if (c == 8'h01 && in_range && !(WPROT && ref_run)) begin
      ref_mem[a] = d; exp_we = 1; exp_lat = 1; exp_q.push_back(4'hA);
    end else if (c == 8'h02 && in_range) begin
      w = ref_mem[a]; exp_re = 1; exp_lat = 2;
      for (int i = 0; i < 8; i++) exp_q.push_back(w[4*i +: 4]);
    end else if (c == 8'h03) begin
      ref_run = 1'b1; exp_q.push_back(4'hA);
    end else if (c == 8'h04) begin
      ref_run = 1'b0; exp_q.push_back(4'hA);
    end else begin
      exp_q.push_back(4'hE);
    end
  endtask

  // Called at a negedge; returns at the negedge of the cycle after acceptance.
  task automatic send_frame(input logic [11:0] a, input logic [7:0] c, input logic [31:0] d);
    int n = 0;
    frame_addr = a; frame_cmd = c; frame_wdata = d; frame_valid = 1'b1;
    while (!frame_ready && n < 300) begin @(negedge clk); n++; end
    if (!frame_ready) begin
      tests++; fails++;
      $display("FAIL frame_accept: frame_ready stuck at %b, required 1", frame_ready);
    end
    @(negedge clk);
    frame_valid = 1'b0;
  endtask

  // mode 0: ready always, 1: ready pattern 1-0-0-1, 2: random ready.
  task automatic collect(input int mode, input int n_exp);
    int cyc = 0;
    logic prev_stall = 1'b0;
    logic [3:0] prev_n = 4'h0;
    got_q.delete(); first_lat = -1; busy_ready = 0; stable_err = 0;
    while (got_q.size() < n_exp && cyc < 300) begin
      case (mode)
        0:       resp_ready = 1'b1;
        1:       resp_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: resp_ready = 1'($urandom_range(0, 1));
      endcase
      if (resp_valid && first_lat < 0) first_lat = cyc;
      if (prev_stall && resp_nibble !== prev_n) stable_err++;
      if (frame_ready) busy_ready++;
      if (resp_valid && resp_ready) got_q.push_back(resp_nibble);
      prev_stall = resp_valid && !resp_ready;
      prev_n = resp_nibble;
      @(negedge clk);
      cyc++;
    end
    resp_ready = 1'b0;
  endtask

  task automatic run_frame(input logic [11:0] a, input logic [7:0] c, input logic [31:0] d,
                           input int mode);
    int we0, re0;
    model(a, c, d);
    we0 = we_cnt; re0 = re_cnt;
    send_frame(a, c, d);
    tests++;
    if (cpu_run !== ref_run) begin fails++;
      $display("FAIL run_at_T1 cmd=%0h: cpu_run=%b required %b", c, cpu_run, ref_run); end
    if (exp_we != 0) begin
      tests++;
      if (mem_we !== 1'b1 || mem_addr !== a[AW-1:0] || mem_wdata !== d) begin fails++;
        $display("FAIL write_strobe: we=%b addr=%0h wdata=%0h required 1 %0h %0h",
                 mem_we, mem_addr, mem_wdata, a[AW-1:0], d); end
    end
    if (exp_re != 0) begin
      tests++;
      if (mem_re !== 1'b1 || mem_addr !== a[AW-1:0]) begin fails++;
        $display("FAIL read_strobe: re=%b addr=%0h required 1 %0h", mem_re, mem_addr, a[AW-1:0]); end
    end
    collect(mode, exp_q.size());
    tests++;
    if (got_q.size() != exp_q.size()) begin fails++;
      $display("FAIL resp_count cmd=%0h: got %0d nibbles required %0d", c, got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        tests++;
        if (got_q[i] !== exp_q[i]) begin fails++;
          $display("FAIL resp_nibble[%0d] cmd=%0h: got %h required %h", i, c, got_q[i], exp_q[i]); end
      end
    end
    tests++;
    if (first_lat != exp_lat) begin fails++;
      $display("FAIL resp_latency cmd=%0h: got %0d required %0d", c, first_lat, exp_lat); end
    tests++;
    if (busy_ready != 0 || stable_err != 0) begin fails++;
      $display("FAIL busy_hold cmd=%0h: ready_while_busy=%0d unstable=%0d required 0 0",
               c, busy_ready, stable_err); end
    tests++;
    if (resp_valid !== 1'b0 || frame_ready !== 1'b1) begin fails++;
      $display("FAIL resp_end cmd=%0h: resp_valid=%b frame_ready=%b required 0 1",
               c, resp_valid, frame_ready); end
    tests++;
    if ((we_cnt - we0) != exp_we || (re_cnt - re0) != exp_re || cpu_run !== ref_run) begin fails++;
      $display("FAIL side_effects cmd=%0h: we=%0d re=%0d run=%b required %0d %0d %b",
               c, we_cnt - we0, re_cnt - re0, cpu_run, exp_we, exp_re, ref_run); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; frame_valid = 1'b0; resp_ready = 1'b0;
    frame_addr = '0; frame_cmd = '0; frame_wdata = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1; ref_run = 1'b0;
    tests++;
    if (frame_ready !== 1'b1 || resp_valid !== 1'b0 || mem_we !== 1'b0 || mem_re !== 1'b0 ||
        cpu_run !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0 || resp_nibble !== 4'h0) begin
      fails++;
      $display("FAIL reset_state: ready=%b rv=%b we=%b re=%b run=%b addr=%0h wd=%0h nib=%h required 1 0 0 0 0 0 0 0",
               frame_ready, resp_valid, mem_we, mem_re, cpu_run, mem_addr, mem_wdata, resp_nibble);
    end
  endtask

  task automatic test_write_read();
    run_frame(12'h005, 8'h01, 32'hDEADBEEF, 0);
    run_frame(12'h005, 8'h02, 32'h0, 0);
    run_frame(12'h005, 8'h02, 32'h0, 1);
  endtask

  task automatic test_errors();
    run_frame(12'h005, 8'h7F, 32'h12345678, 0);
    run_frame(12'h400, 8'h01, 32'hCAFEF00D, 0);
    run_frame(12'hFFF, 8'h02, 32'h0, 1);
  endtask

  task automatic test_run_halt();
    run_frame(12'h000, 8'h03, 32'h0, 0);
    run_frame(12'h000, 8'h03, 32'h0, 0);
    run_frame(12'h000, 8'h01, 32'h0BADF00D, 0);
    run_frame(12'h000, 8'h02, 32'h0, 0);
    run_frame(12'h000, 8'h04, 32'h0, 0);
    run_frame(12'h000, 8'h04, 32'h0, 0);
  endtask

  // A frame held during a busy response must wait until the response drains.
  task automatic test_back_pressure();
    logic [31:0] got_w;
    ref_mem[9] = 32'h13579BDF;
    ram[9] = 32'h13579BDF;
    model(12'h009, 8'h02, 32'h0);
    send_frame(12'h009, 8'h02, 32'h0);
    frame_addr = 12'h0; frame_cmd = 8'h03; frame_wdata = '0; frame_valid = 1'b1;
    resp_ready = 1'b0;
    repeat (6) @(negedge clk);
    tests++;
    if (cpu_run !== 1'b0 || frame_ready !== 1'b0 || resp_valid !== 1'b1) begin fails++;
      $display("FAIL held_frame: run=%b ready=%b rv=%b required 0 0 1", cpu_run, frame_ready, resp_valid); end
    collect(0, 8);
    got_w = '0;
    for (int i = 0; i < got_q.size() && i < 8; i++) got_w[4*i +: 4] = got_q[i];
    tests++;
    if (got_q.size() != 8 || got_w !== 32'h13579BDF) begin fails++;
      $display("FAIL bp_read_word: got %0d nibbles word %h required 8 13579bdf", got_q.size(), got_w); end
    model(12'h0, 8'h03, 32'h0);
    @(negedge clk);
    frame_valid = 1'b0;
    tests++;
    if (cpu_run !== 1'b1 || resp_valid !== 1'b1 || resp_nibble !== 4'hA) begin fails++;
      $display("FAIL bp_run_after: run=%b rv=%b nib=%h required 1 1 a", cpu_run, resp_valid, resp_nibble); end
    collect(0, 1);
  endtask

  task automatic test_reset_mid_response();
    int n = 0, cyc = 0;
    run_frame(12'h001, 8'h01, 32'h89ABCDEF, 0);
    run_frame(12'h000, 8'h03, 32'h0, 0);
    model(12'h001, 8'h02, 32'h0);
    send_frame(12'h001, 8'h02, 32'h0);
    resp_ready = 1'b1;
    while (n < 3 && cyc < 50) begin
      if (resp_valid) n++;
      @(negedge clk); cyc++;
    end
    tests++;
    if (resp_valid !== 1'b1 || resp_nibble !== exp_q[3]) begin fails++;
      $display("FAIL fourth_nibble: rv=%b nib=%h required 1 %h", resp_valid, resp_nibble, exp_q[3]); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; resp_ready = 1'b0; ref_run = 1'b0;
    tests++;
    if (resp_valid !== 1'b0 || cpu_run !== 1'b0 || frame_ready !== 1'b1) begin fails++;
      $display("FAIL reset_mid_resp: rv=%b run=%b ready=%b required 0 0 1", resp_valid, cpu_run, frame_ready); end
    run_frame(12'h002, 8'h01, 32'h55AA33CC, 0);
    run_frame(12'h002, 8'h02, 32'h0, 0);
  endtask

  task automatic test_random();
    logic [11:0] a;
    logic [7:0]  c;
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 5))
        0:       c = 8'h01;
        1, 2:    c = 8'h02;
        3:       c = 8'h03;
        4:       c = 8'h04;
        default: c = 8'($urandom);
      endcase
      if ($urandom_range(0, 7) == 0) a = 12'($urandom);
      else a = 12'($urandom_range(0, 15));
      run_frame(a, c, $urandom, int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin ram[i] = '0; ref_mem[i] = '0; end
    mem_rdata = '0;
    test_reset();
    test_write_read();
    test_errors();
    test_run_halt();
    test_back_pressure();
    test_reset_mid_response();
    test_random();
    tests++;
    if (both_cnt != 0) begin fails++;
      $display("FAIL strobe_overlap: we&re seen %0d cycles, required 0", both_cnt); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
